// File: rtl/fp_sqrt_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_iter_if
// Purpose  : Operand/result handshake bundle for the iterative square root.
//            "master" is the side that issues operands and takes results,
//            "slave" is the square-root engine.
// Revision : 1.0  initial release
// ============================================================================
interface fp_sqrt_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    localparam int c_w = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [c_w-1:0]   in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [c_w-1:0]   out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_invalid;
    logic             out_inexact;
    logic             busy;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_invalid, out_inexact, busy
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_invalid, out_inexact, busy
    );
endinterface
`default_nettype wire

// File: rtl/fp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_sqrt_iter
// Purpose  : Sequential IEEE-754 square root, one root bit per clock using
//            restoring digit recurrence, round-to-nearest-even, denormals
//            flushed to zero. Single operation in flight with valid/ready
//            handshakes and a pass-through tag.
// Revision : 1.0  initial release
// ============================================================================
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fp_sqrt_iter_if.slave bus
);
    localparam int c_w      = 1 + EXP_W + MAN_W;
    localparam int c_n      = MAN_W + 2;          // root bits: MAN_W+1 significand + guard
    localparam int c_rad_w  = 2 * c_n;
    localparam int c_rem_w  = c_n + 2;            // partial remainder never exceeds 2*root
    localparam int c_acc_w  = c_rem_w + 2;
    localparam int c_cnt_w  = $clog2(c_n + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n - 1);
    localparam logic [EXP_W-1:0]   c_bias     = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [c_w-1:0]     c_qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_round = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_rad_w-1:0] r_rad;
    logic [c_rem_w-1:0] r_rem;
    logic [c_n-1:0]     r_root;
    logic [EXP_W-1:0]   r_exp;
    logic               r_special;
    logic [c_w-1:0]     r_spec_data;
    logic               r_spec_invalid;
    logic [TAG_W-1:0]   r_tag;
    logic [c_w-1:0]     r_out_data;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_invalid;
    logic               r_out_inexact;

    // ---------------- operand classification (IDLE capture) ----------------
    logic               w_sign;
    logic [EXP_W-1:0]   w_e;
    logic [MAN_W-1:0]   w_f;
    logic               w_special;
    logic [c_w-1:0]     w_spec_data;
    logic               w_spec_invalid;
    logic [EXP_W:0]     w_exp_sum;
    logic               w_odd;
    logic [c_rad_w-1:0] w_sig_ext;
    logic [c_rad_w-1:0] w_rad;

    assign w_sign = bus.in_data[c_w-1];
    assign w_e    = bus.in_data[c_w-2 -: EXP_W];
    assign w_f    = bus.in_data[MAN_W-1:0];

    // Result exponent is floor((E + bias) / 2); the dropped LSB is exactly the
    // "unbiased exponent is odd" flag because the bias itself is odd.
    assign w_exp_sum = {1'b0, w_e} + {1'b0, c_bias};
    assign w_odd     = w_exp_sum[0];
    assign w_sig_ext = {{(c_rad_w-MAN_W-1){1'b0}}, 1'b1, w_f};
    assign w_rad     = w_odd ? (w_sig_ext << (MAN_W + 3)) : (w_sig_ext << (MAN_W + 2));

    // Special-operand result, fixed at capture; NaNs take priority over sign.
    always_comb begin
        w_special      = 1'b1;
        w_spec_data    = '0;
        w_spec_invalid = 1'b0;
        if ((&w_e) && (|w_f)) begin
            w_spec_data    = c_qnan;
            w_spec_invalid = ~w_f[MAN_W-1];
        end else if (w_e == '0) begin
            w_spec_data = {w_sign, {(c_w-1){1'b0}}};
        end else if (w_sign) begin
            w_spec_data    = c_qnan;
            w_spec_invalid = 1'b1;
        end else if (&w_e) begin
            w_spec_data = bus.in_data;
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- one recurrence step (CALC) ----------------
    logic [c_acc_w-1:0] w_acc;
    logic [c_acc_w-1:0] w_sub;
    logic               w_ge;
    logic [c_rem_w-1:0] w_rem_next;

    assign w_acc      = {r_rem, r_rad[c_rad_w-1 -: 2]};
    assign w_sub      = {2'b00, r_root, 2'b01};
    assign w_ge       = (w_acc >= w_sub);
    // The true remainder always fits c_rem_w bits, so modular subtraction is exact.
    assign w_rem_next = w_ge ? (w_acc[c_rem_w-1:0] - w_sub[c_rem_w-1:0]) : w_acc[c_rem_w-1:0];

    // ---------------- round to nearest even (ROUND) ----------------
    logic               w_guard;
    logic               w_sticky;
    logic               w_up;
    logic [MAN_W+1:0]   w_sig_rnd;
    logic               w_carry;
    logic [MAN_W-1:0]   w_frac;
    logic [c_w-1:0]     w_norm_data;

    assign w_guard     = r_root[0];
    assign w_sticky    = |r_rem;
    assign w_up        = w_guard & (w_sticky | r_root[1]);
    assign w_sig_rnd   = {1'b0, r_root[c_n-1:1]} + {{(MAN_W+1){1'b0}}, w_up};
    assign w_carry     = w_sig_rnd[MAN_W+1];
    assign w_frac      = w_carry ? w_sig_rnd[MAN_W:1] : w_sig_rnd[MAN_W-1:0];
    assign w_norm_data = {1'b0, r_exp + {{(EXP_W-1){1'b0}}, w_carry}, w_frac};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: fixed-length CALC regardless of operand class.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (bus.in_valid) w_state_next = c_st_calc;
            c_st_calc:  if (r_cnt == c_cnt_last) w_state_next = c_st_round;
            c_st_round: w_state_next = c_st_done;
            c_st_done:  if (bus.out_ready) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // Datapath: capture, iterate, round; outputs hold until the next ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_rad          <= '0;
            r_rem          <= '0;
            r_root         <= '0;
            r_exp          <= '0;
            r_special      <= 1'b0;
            r_spec_data    <= '0;
            r_spec_invalid <= 1'b0;
            r_tag          <= '0;
            r_out_data     <= '0;
            r_out_tag      <= '0;
            r_out_invalid  <= 1'b0;
            r_out_inexact  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_cnt          <= '0;
                        r_rad          <= w_rad;
                        r_rem          <= '0;
                        r_root         <= '0;
                        r_exp          <= w_exp_sum[EXP_W:1];
                        r_special      <= w_special;
                        r_spec_data    <= w_spec_data;
                        r_spec_invalid <= w_spec_invalid;
                        r_tag          <= bus.in_tag;
                    end
                end
                c_st_calc: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= {r_root[c_n-2:0], w_ge};
                end
                c_st_round: begin
                    r_out_data    <= r_special ? r_spec_data : w_norm_data;
                    r_out_tag     <= r_tag;
                    r_out_invalid <= r_special & r_spec_invalid;
                    r_out_inexact <= ~r_special & (w_guard | w_sticky);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == c_st_idle);
    assign bus.out_valid   = (r_state == c_st_done);
    assign bus.busy        = (r_state != c_st_idle);
    assign bus.out_data    = r_out_data;
    assign bus.out_tag     = r_out_tag;
    assign bus.out_invalid = r_out_invalid;
    assign bus.out_inexact = r_out_inexact;
endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_sqrt_iter
// Purpose  : Directed, table-driven bench for fp_sqrt_iter (binary32 and
//            binary16 instances) plus hold, abort and latency sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_sqrt_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus32 ();
    fp_sqrt_iter_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) bus16 ();

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    typedef struct {
        logic [31:0] din;
        logic [3:0]  tag;
        logic [31:0] dout;
        logic        inv;
        logic        inx;
    } vec_t;

    vec_t vecs[15];

    // Bounded run-time guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Issue one binary32 operand and wait for out_valid; in_data/in_valid are
    // wiggled while busy to show they are ignored.
    task automatic op32(input logic [31:0] d, input logic [3:0] t,
                        output logic [31:0] rd, output logic [3:0] rt,
                        output logic rinv, output logic rinx, output int lat);
        int w;
        w = 0;
        while (!bus32.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus32.in_data  = d;
        bus32.in_tag   = t;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.in_data  = ~d;
        bus32.in_tag   = ~t;
        lat = 0;
        while (!bus32.out_valid && lat < 100) begin
            bus32.in_valid = lat[0];
            @(posedge clk); #1; lat++;
        end
        bus32.in_valid = 1'b0;
        rd   = bus32.out_data;
        rt   = bus32.out_tag;
        rinv = bus32.out_invalid;
        rinx = bus32.out_inexact;
    endtask

    task automatic deliver32(input string nm);
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        check({nm, " in_ready after accept"}, {31'd0, bus32.in_ready}, 32'd1);
        check({nm, " out_valid after accept"}, {31'd0, bus32.out_valid}, 32'd0);
    endtask

    task automatic op16(input logic [15:0] d, input logic [15:0] exp, input logic exinx);
        int lat;
        bus16.in_data  = d;
        bus16.in_tag   = 4'd9;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check($sformatf("b16 %h latency", d), lat, 32'd13);
        check($sformatf("b16 %h data", d), {16'd0, bus16.out_data}, {16'd0, exp});
        check($sformatf("b16 %h inexact", d), {31'd0, bus16.out_inexact}, {31'd0, exinx});
        check($sformatf("b16 %h tag", d), {28'd0, bus16.out_tag}, 32'd9);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        check($sformatf("b16 %h in_ready after accept", d), {31'd0, bus16.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  rt;
        logic        rinv, rinx;
        int          lat;
        logic [31:0] held;
        logic        seen;

        vecs[0]  = '{32'h40000000, 4'd3,  32'h3fb504f3, 1'b0, 1'b1};
        vecs[1]  = '{32'h40800000, 4'd1,  32'h40000000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3e800000, 4'd2,  32'h3f000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h49742400, 4'd4,  32'h447a0000, 1'b0, 1'b0};
        vecs[4]  = '{32'h3f800000, 4'd5,  32'h3f800000, 1'b0, 1'b0};
        vecs[5]  = '{32'h40a00000, 4'd6,  32'h400f1bbd, 1'b0, 1'b1};
        vecs[6]  = '{32'hbf800000, 4'd7,  32'h7fc00000, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 4'd8,  32'h80000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000001, 4'd9,  32'h00000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h7f800000, 4'd10, 32'h7f800000, 1'b0, 1'b0};
        vecs[10] = '{32'h7f800001, 4'd11, 32'h7fc00000, 1'b1, 1'b0};
        vecs[11] = '{32'h7fc00000, 4'd12, 32'h7fc00000, 1'b0, 1'b0};
        vecs[12] = '{32'h7f7fffff, 4'd13, 32'h5f7fffff, 1'b0, 1'b1};
        vecs[13] = '{32'h00800000, 4'd14, 32'h20000000, 1'b0, 1'b0};
        vecs[14] = '{32'h3f7fffff, 4'd15, 32'h3f7fffff, 1'b0, 1'b1};

        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_tag = '0; bus32.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_tag = '0; bus16.out_ready = 1'b0;

        // Reset for two cycles, then check idle outputs.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset in_ready",  {31'd0, bus32.in_ready},  32'd1);
        check("reset out_valid", {31'd0, bus32.out_valid}, 32'd0);
        check("reset busy",      {31'd0, bus32.busy},      32'd0);
        check("reset out_data",  bus32.out_data,           32'd0);
        check("reset out_tag",   {28'd0, bus32.out_tag},   32'd0);

        // Table-driven vectors, issued back to back.
        for (int i = 0; i < 15; i++) begin
            op32(vecs[i].din, vecs[i].tag, rd, rt, rinv, rinx, lat);
            check($sformatf("vec%0d latency", i), lat, 32'd26);
            check($sformatf("vec%0d data", i), rd, vecs[i].dout);
            check($sformatf("vec%0d tag", i), {28'd0, rt}, {28'd0, vecs[i].tag});
            check($sformatf("vec%0d invalid", i), {31'd0, rinv}, {31'd0, vecs[i].inv});
            check($sformatf("vec%0d inexact", i), {31'd0, rinx}, {31'd0, vecs[i].inx});
            check($sformatf("vec%0d busy", i), {31'd0, bus32.busy}, 32'd1);
            deliver32($sformatf("vec%0d", i));
        end

        // Backpressure: hold out_ready low for 10 cycles.
        op32(32'h40800000, 4'd6, rd, rt, rinv, rinx, lat);
        held = rd;
        check("hold initial data", held, 32'h40000000);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold c%0d data", c), bus32.out_data, held);
            check($sformatf("hold c%0d out_valid", c), {31'd0, bus32.out_valid}, 32'd1);
            check($sformatf("hold c%0d in_ready", c), {31'd0, bus32.in_ready}, 32'd0);
            check($sformatf("hold c%0d tag", c), {28'd0, bus32.out_tag}, 32'd6);
        end
        deliver32("hold");

        // Abort with reset during CALC cycle 10.
        bus32.in_data  = 32'h40000000;
        bus32.in_tag   = 4'd5;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("abort busy before reset", {31'd0, bus32.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready",  {31'd0, bus32.in_ready},  32'd1);
        check("abort out_valid", {31'd0, bus32.out_valid}, 32'd0);
        check("abort busy",      {31'd0, bus32.busy},      32'd0);
        check("abort out_data",  bus32.out_data,           32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus32.out_valid) seen = 1'b1;
        end
        check("abort no out_valid", {31'd0, seen}, 32'd0);
        op32(32'h3d800000, 4'd2, rd, rt, rinv, rinx, lat);
        check("post-abort latency", lat, 32'd26);
        check("post-abort data", rd, 32'h3e800000);
        check("post-abort tag", {28'd0, rt}, 32'd2);
        deliver32("post-abort");

        // Binary16 instance.
        op16(16'h4000, 16'h3da8, 1'b1);
        op16(16'h4400, 16'h4000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
